// File: rtl/mdu_ctrl.sv
// Multiply/divide scheduler beside the E-stage ALU: owns HI/LO, computes the
// result at start, then holds Busy for a fixed latency before committing it.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;

  logic          w_is_mul, w_is_div, w_launch, w_last, w_b0;
  logic [63:0]   w_prod_s, w_prod_u;
  logic [31:0]   w_ua, w_ub, w_sdiv_b, w_udiv_b;
  logic [31:0]   w_q_mag, w_r_mag, w_sq, w_sr, w_uq, w_ur;
  logic [31:0]   w_res_hi, w_res_lo;

  assign w_is_mul = Start && (MDUOp == 3'd1 || MDUOp == 3'd2);
  assign w_is_div = Start && (MDUOp == 3'd3 || MDUOp == 3'd4);
  assign w_launch = (r_state == S_IDLE) && (w_is_mul || w_is_div);
  assign w_last   = (r_cnt == CW'(1));

  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_ua     = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
  assign w_ub     = SrcB[31] ? (~SrcB + 32'd1) : SrcB;
  assign w_b0     = (SrcB == 32'd0);
  assign w_sdiv_b = w_b0 ? 32'd1 : w_ub;
  assign w_udiv_b = w_b0 ? 32'd1 : SrcB;
  assign w_q_mag  = w_ua / w_sdiv_b;
  assign w_r_mag  = w_ua % w_sdiv_b;
  assign w_sq     = (SrcA[31] ^ SrcB[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_sr     = SrcA[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_uq     = SrcA / w_udiv_b;
  assign w_ur     = SrcA % w_udiv_b;

  // Divide by zero leaves HI/LO as they are at commit time.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (MDUOp)
      3'd1: begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      3'd2: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      3'd3: if (!w_b0) begin w_res_hi = w_sr; w_res_lo = w_sq; end
      3'd4: if (!w_b0) begin w_res_hi = w_ur; w_res_lo = w_uq; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (w_launch) begin
          r_pend_hi <= w_res_hi;
          r_pend_lo <= w_res_lo;
          r_cnt     <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (Start && MDUOp == 3'd5) begin
          r_hi <= SrcA;
        end else if (Start && MDUOp == 3'd6) begin
          r_lo <= SrcA;
        end
      end else begin
        // Starts arriving while running are dropped on purpose.
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end
    end
  end

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: cycle-by-cycle comparison against a commit-time model,
// directed literal checks, then randomized traffic with occasional resets.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [2:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op at edge t commits at edge t+N; busy while a commit is pending.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi, m_plo;
  longint      ecyc = 0;
  longint      m_commit = -1;
  bit          m_ok = 0;

  task automatic calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] oh, input logic [31:0] ol,
                      output logic [31:0] ph, output logic [31:0] pl);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    ph = oh;
    pl = ol;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); ph = p[63:32]; pl = p[31:0]; end
      3'd2: begin pu = 64'(a) * 64'(b); ph = pu[63:32]; pl = pu[31:0]; end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          pl = 32'h8000_0000; ph = 32'h0;
        end else begin
          pl = sa / sb; ph = sa % sb;
        end
      end
      3'd4: if (b != 0) begin pl = a / b; ph = a % b; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    ecyc++;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_commit = -1; m_ok = 1;
    end else if (m_commit >= 0) begin
      if (ecyc == m_commit) begin
        m_hi = m_phi; m_lo = m_plo; m_commit = -1;
      end
    end else if (Start) begin
      case (MDUOp)
        3'd1, 3'd2: begin calc(MDUOp, SrcA, SrcB, m_hi, m_lo, m_phi, m_plo); m_commit = ecyc + MC; end
        3'd3, 3'd4: begin calc(MDUOp, SrcA, SrcB, m_hi, m_lo, m_phi, m_plo); m_commit = ecyc + DC; end
        3'd5: m_hi = SrcA;
        3'd6: m_lo = SrcA;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cyc_busy", {31'd0, Busy}, {31'd0, (m_commit >= 0)});
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    step();
    Start = 1'b0; MDUOp = 3'd0;
  endtask

  // Counts remaining Busy cycles, bounded so a stuck Busy still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; SrcA = '0; SrcB = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);

    issue(3'd5, 32'h1234_5678, 32'h0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    check("mtlo_busy", {31'd0, Busy}, 32'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(n);
    check("mult_lat", n, MC);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done(n);
    check("multu_lat", n, MC);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_lat", n, DC);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_done(n);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0);

    issue(3'd5, 32'hA, 32'h0);
    issue(3'd6, 32'hB, 32'h0);
    issue(3'd4, 32'd7, 32'd0);
    wait_done(n);
    check("div0_lat", n, DC);
    check("div0_hi", HI, 32'hA);
    check("div0_lo", LO, 32'hB);

    // Starts during RUN must be dropped; MULT 3*4 still commits after 5 cycles.
    issue(3'd1, 32'd3, 32'd4);
    Start = 1'b1; MDUOp = 3'd3; SrcA = 32'd100; SrcB = 32'd7;
    step();
    MDUOp = 3'd6; SrcA = 32'hDEAD_BEEF;
    step();
    Start = 1'b0; MDUOp = 3'd0;
    check("ign_busy", {31'd0, Busy}, 32'd1);
    wait_done(n);
    check("ign_lat", n, MC - 2);
    check("ign_hi", HI, 32'h0);
    check("ign_lo", LO, 32'd12);

    issue(3'd3, 32'd100, 32'd7);
    step(); step(); step();
    check("midrst_busy_pre", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    repeat (12) step();
    check("midrst_late_hi", HI, 32'h0);
    check("midrst_late_lo", LO, 32'h0);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) == 0);
      Start = 1'($urandom_range(1));
      MDUOp = 3'($urandom_range(7));
      SrcA  = pick();
      SrcB  = pick();
      step();
    end
    reset = 1'b0; Start = 1'b0; MDUOp = 3'd0;
    repeat (DC + 2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
